// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper array driver: the half-step coil table,
// mode encodings, the channel state enum and helpers for phase handling.
package stepper_pkg;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [1:0] MODE_WAVE = 2'd0;
    localparam logic [1:0] MODE_FULL = 2'd1;
    localparam logic [1:0] MODE_HALF = 2'd2;

    // Half-step coil patterns {D,C,B,A}; entry [0] is phase 0.
    localparam logic [7:0][3:0] PHASE_TABLE = {
        4'b1001, 4'b1000, 4'b1100, 4'b0100,
        4'b0110, 4'b0010, 4'b0011, 4'b0001
    };

    function automatic logic [3:0] coil_pattern(input logic [2:0] idx);
        return PHASE_TABLE[idx];
    endfunction

    // Wave drive lives on even phases, full (two-coil) drive on odd phases.
    function automatic logic [2:0] align_phase(input logic [2:0] phase, input logic [1:0] mode);
        logic [2:0] res;
        case (mode)
            MODE_WAVE: res = phase & 3'b110;
            MODE_FULL: res = phase | 3'b001;
            default:   res = phase;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/stepper_channel.sv
// One stepper channel: period timer, remaining-step counter, phase, position
// and the IDLE/RUN state machine. Coil and done are registered.
module stepper_channel
    import stepper_pkg::*;
#(
    parameter int PER_W = 24,
    parameter int CNT_W = 16,
    parameter int POS_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             accept,
    input  logic             cmd_dir,
    input  logic [1:0]       cmd_mode,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [PER_W-1:0] cmd_period,
    input  logic             cmd_hold,
    input  logic             stop,
    output logic [3:0]       coil,
    output logic             busy,
    output logic             done,
    output logic [POS_W-1:0] pos
);

    state_t             state_r, state_next;
    logic [2:0]         phase_r;
    logic               dir_r;
    logic               half_r;
    logic               hold_r;
    logic [PER_W-1:0]   per_r;
    logic [PER_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   steps_left_r;
    logic [POS_W-1:0]   pos_r;
    logic               zero_pend_r;
    logic               done_r;
    logic [3:0]         coil_r;

    logic               step_now_s;
    logic               last_step_s;
    logic [2:0]         phase_adv_s;
    logic [2:0]         aligned_s;
    logic [3:0]         coil_next;

    // Step strobe: stop in the same cycle suppresses the step.
    always_comb begin
        step_now_s  = (state_r == S_RUN) && !stop && (cnt_r == per_r);
        last_step_s = step_now_s && (steps_left_r == CNT_W'(1));
        if (dir_r) begin
            phase_adv_s = phase_r + (half_r ? 3'd1 : 3'd2);
        end else begin
            phase_adv_s = phase_r - (half_r ? 3'd1 : 3'd2);
        end
        aligned_s = align_phase(phase_r, cmd_mode);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Next-state logic: accept starts a non-empty move; stop or the last step ends it.
    always_comb begin
        state_next = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept && (cmd_steps != {CNT_W{1'b0}})) begin
                    state_next = S_RUN;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (stop || last_step_s) begin
                    state_next = S_IDLE;
                end else begin
                    state_next = S_RUN;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output logic: next coil pattern; idle coils drop to zero unless hold is set.
    always_comb begin
        coil_next = 4'b0000;
        if (accept) begin
            coil_next = coil_pattern(aligned_s);
        end else if (step_now_s) begin
            coil_next = coil_pattern(phase_adv_s);
        end else if ((state_r == S_RUN) && !stop) begin
            coil_next = coil_pattern(phase_r);
        end else if (hold_r) begin
            coil_next = coil_pattern(phase_r);
        end else begin
            coil_next = 4'b0000;
        end
    end

    // Datapath: command latch, period timer, phase/position/step bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_r      <= 3'd0;
            dir_r        <= 1'b0;
            half_r       <= 1'b0;
            hold_r       <= 1'b0;
            per_r        <= {PER_W{1'b0}};
            cnt_r        <= {PER_W{1'b0}};
            steps_left_r <= {CNT_W{1'b0}};
            pos_r        <= {POS_W{1'b0}};
            zero_pend_r  <= 1'b0;
            done_r       <= 1'b0;
            coil_r       <= 4'b0000;
        end else begin
            if (accept) begin
                dir_r        <= cmd_dir;
                half_r       <= cmd_mode[1];
                hold_r       <= cmd_hold;
                per_r        <= (cmd_period == {PER_W{1'b0}}) ? {PER_W{1'b0}}
                                                              : cmd_period - PER_W'(1);
                steps_left_r <= cmd_steps;
                cnt_r        <= {PER_W{1'b0}};
                phase_r      <= aligned_s;
            end else if (step_now_s) begin
                phase_r      <= phase_adv_s;
                pos_r        <= dir_r ? pos_r + POS_W'(1) : pos_r - POS_W'(1);
                steps_left_r <= steps_left_r - CNT_W'(1);
                cnt_r        <= {PER_W{1'b0}};
            end else if (state_r == S_RUN) begin
                cnt_r        <= cnt_r + PER_W'(1);
            end else begin
                cnt_r        <= cnt_r;
            end
            zero_pend_r <= accept && (cmd_steps == {CNT_W{1'b0}});
            done_r      <= last_step_s || zero_pend_r;
            coil_r      <= coil_next;
        end
    end

    assign coil = coil_r;
    assign busy = (state_r == S_RUN);
    assign done = done_r;
    assign pos  = pos_r;

endmodule

// File: rtl/stepper_array_drv.sv
// N-channel unipolar stepper driver: command decode and ready mux, out-of-range
// command error pulse, and packing of per-channel outputs onto flat buses.
module stepper_array_drv
    import stepper_pkg::*;
#(
    parameter int N_CH  = 2,
    parameter int PER_W = 24,
    parameter int CNT_W = 16,
    parameter int POS_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_ch,
    input  logic                  cmd_dir,
    input  logic [1:0]            cmd_mode,
    input  logic [CNT_W-1:0]      cmd_steps,
    input  logic [PER_W-1:0]      cmd_period,
    input  logic                  cmd_hold,
    input  logic [N_CH-1:0]       stop,
    output logic [4*N_CH-1:0]     coil,
    output logic [N_CH-1:0]       busy,
    output logic [N_CH-1:0]       done,
    output logic                  cmd_err,
    output logic [POS_W*N_CH-1:0] pos
);

    localparam logic [3:0] N_CH_L = 4'(N_CH);

    logic            in_range_s;
    logic            sel_busy_s;
    logic [N_CH-1:0] accept_s;
    logic            cmd_err_r;

    // Ready mux: out-of-range commands are always taken (and dropped).
    always_comb begin
        in_range_s = ({1'b0, cmd_ch} < N_CH_L);
        sel_busy_s = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (cmd_ch == 3'(i)) begin
                sel_busy_s = busy[i];
            end else begin
                sel_busy_s = sel_busy_s;
            end
        end
        if (!in_range_s) begin
            cmd_ready = 1'b1;
        end else begin
            cmd_ready = ~sel_busy_s;
        end
    end

    // Per-channel accept strobes.
    always_comb begin
        accept_s = {N_CH{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            accept_s[i] = cmd_valid && cmd_ready && in_range_s && (cmd_ch == 3'(i));
        end
    end

    // One-cycle error pulse for a dropped out-of-range command.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_err_r <= 1'b0;
        end else begin
            cmd_err_r <= cmd_valid && !in_range_s;
        end
    end

    assign cmd_err = cmd_err_r;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        stepper_channel #(
            .PER_W (PER_W),
            .CNT_W (CNT_W),
            .POS_W (POS_W)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .accept     (accept_s[g]),
            .cmd_dir    (cmd_dir),
            .cmd_mode   (cmd_mode),
            .cmd_steps  (cmd_steps),
            .cmd_period (cmd_period),
            .cmd_hold   (cmd_hold),
            .stop       (stop[g]),
            .coil       (coil[4*g +: 4]),
            .busy       (busy[g]),
            .done       (done[g]),
            .pos        (pos[POS_W*g +: POS_W])
        );
    end

endmodule

// File: tb/tb_stepper_array_drv.sv
// Directed bench for stepper_array_drv (2 channels, 4-bit position to exercise wrap).
// Done events are checked by a scoreboard monitor; coil/busy/ready timing inline.
module tb_stepper_array_drv;

    localparam int N_CH  = 2;
    localparam int PER_W = 24;
    localparam int CNT_W = 16;
    localparam int POS_W = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [2:0]            cmd_ch;
    logic                  cmd_dir;
    logic [1:0]            cmd_mode;
    logic [CNT_W-1:0]      cmd_steps;
    logic [PER_W-1:0]      cmd_period;
    logic                  cmd_hold;
    logic [N_CH-1:0]       stop;
    logic [4*N_CH-1:0]     coil;
    logic [N_CH-1:0]       busy;
    logic [N_CH-1:0]       done;
    logic                  cmd_err;
    logic [POS_W*N_CH-1:0] pos;

    typedef struct {
        int         ch;
        logic [3:0] pos;
        logic [3:0] coil;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    stepper_array_drv #(
        .N_CH  (N_CH),
        .PER_W (PER_W),
        .CNT_W (CNT_W),
        .POS_W (POS_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_ch     (cmd_ch),
        .cmd_dir    (cmd_dir),
        .cmd_mode   (cmd_mode),
        .cmd_steps  (cmd_steps),
        .cmd_period (cmd_period),
        .cmd_hold   (cmd_hold),
        .stop       (stop),
        .coil       (coil),
        .busy       (busy),
        .done       (done),
        .cmd_err    (cmd_err),
        .pos        (pos)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue one command; returns 1 time unit after the accepting edge.
    task automatic send(input logic [2:0] ch, input logic dir, input logic [1:0] mode,
                        input int steps, input int period, input logic hold);
        cmd_ch     = ch;
        cmd_dir    = dir;
        cmd_mode   = mode;
        cmd_steps  = CNT_W'(steps);
        cmd_period = PER_W'(period);
        cmd_hold   = hold;
        cmd_valid  = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid  = 1'b0;
    endtask

    task automatic expect_done(input int ch, input logic [3:0] p, input logic [3:0] c);
        exp_t e;
        e.ch   = ch;
        e.pos  = p;
        e.coil = c;
        sb_q.push_back(e);
    endtask

    // Monitor: every done pulse must match the next expected completion.
    always @(negedge clk) begin
        for (int c = 0; c < N_CH; c++) begin
            if (done[c]) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected ch=%0d pos=%0h coil=%b @%0t",
                             c, pos[POS_W*c +: POS_W], coil[4*c +: 4], $time);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (mon_e.ch != c || mon_e.pos !== pos[POS_W*c +: POS_W] ||
                        mon_e.coil !== coil[4*c +: 4]) begin
                        errors++;
                        $display("FAIL done_event actual ch=%0d pos=%0h coil=%b expected ch=%0d pos=%0h coil=%b @%0t",
                                 c, pos[POS_W*c +: POS_W], coil[4*c +: 4],
                                 mon_e.ch, mon_e.pos, mon_e.coil, $time);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_ch = 3'd0; cmd_dir = 1'b0; cmd_mode = 2'd0;
        cmd_steps = '0; cmd_period = '0; cmd_hold = 1'b0; stop = 2'b00;
        tick(3);
        chk("reset_coil", coil, 8'h00);
        chk("reset_busy", busy, 2'b00);
        chk("reset_done", done, 2'b00);
        chk("reset_err", cmd_err, 1'b0);
        chk("reset_pos", pos, 8'h00);
        reset = 1'b0;
        tick(1);

        // Half step forward, 3 steps, period 4.
        expect_done(0, 4'd3, 4'b0110);
        send(3'd0, 1'b1, 2'd2, 3, 4, 1'b0);
        chk("t1_coil_k", coil[3:0], 4'b0001);
        chk("t1_busy_k", busy[0], 1'b1);
        tick(4);
        chk("t1_coil_4", coil[3:0], 4'b0011);
        cmd_ch = 3'd0;
        #1;
        chk("t4_ready_busy", cmd_ready, 1'b0);
        tick(4);
        chk("t1_coil_8", coil[3:0], 4'b0010);
        tick(4);
        chk("t1_coil_12", coil[3:0], 4'b0110);
        chk("t1_busy_12", busy[0], 1'b0);
        chk("t1_pos", pos[3:0], 4'd3);
        tick(1);
        chk("t1_coil_idle", coil[3:0], 4'b0000);

        // Out-of-range command is taken and dropped.
        cmd_ch = 3'd5; cmd_steps = CNT_W'(7); cmd_valid = 1'b1;
        #1;
        chk("t4_ready_oor", cmd_ready, 1'b1);
        tick(1);
        cmd_valid = 1'b0;
        chk("t4_err_pulse", cmd_err, 1'b1);
        chk("t4_busy", busy, 2'b00);
        chk("t4_pos", pos, 8'h03);
        tick(1);
        chk("t4_err_clear", cmd_err, 1'b0);

        // Full step reverse on ch1, period 1.
        expect_done(1, 4'he, 4'b1100);
        send(3'd1, 1'b0, 2'd1, 2, 1, 1'b0);
        chk("t2_align", coil[7:4], 4'b0011);
        chk("t2_busy", busy[1], 1'b1);
        tick(1);
        chk("t2_step1", coil[7:4], 4'b1001);
        tick(1);
        chk("t2_step2", coil[7:4], 4'b1100);
        chk("t2_busy_end", busy[1], 1'b0);
        tick(1);
        chk("t2_idle", coil[7:4], 4'b0000);

        // Wave with hold, aborted by stop after 2 steps.
        send(3'd0, 1'b1, 2'd0, 10, 5, 1'b1);
        chk("t3_align", coil[3:0], 4'b0010);
        tick(5);
        chk("t3_step1", coil[3:0], 4'b0100);
        tick(5);
        chk("t3_step2", coil[3:0], 4'b1000);
        tick(2);
        stop = 2'b01;
        tick(1);
        stop = 2'b00;
        chk("t3_busy_stop", busy[0], 1'b0);
        chk("t3_coil_hold", coil[3:0], 4'b1000);
        chk("t3_pos", pos[3:0], 4'd5);
        tick(5);
        chk("t3_no_step", coil[3:0], 4'b1000);
        chk("t3_pos_after", pos[3:0], 4'd5);

        // Zero-step command: alignment only, done one cycle later.
        expect_done(0, 4'd5, 4'b0000);
        send(3'd0, 1'b1, 2'd1, 0, 3, 1'b0);
        chk("t5_align", coil[3:0], 4'b1001);
        chk("t5_busy_k", busy[0], 1'b0);
        tick(1);
        chk("t5_done", done[0], 1'b1);
        chk("t5_busy_k1", busy[0], 1'b0);
        tick(1);
        chk("t5_done_clear", done[0], 1'b0);

        // Period 0 on ch1: one step per cycle, position wraps 14 -> 1.
        expect_done(1, 4'd1, 4'b0001);
        send(3'd1, 1'b1, 2'd3, 3, 0, 1'b1);
        chk("t5p_k", coil[7:4], 4'b1100);
        tick(1);
        chk("t5p_1", coil[7:4], 4'b1000);
        tick(1);
        chk("t5p_2", coil[7:4], 4'b1001);
        tick(1);
        chk("t5p_3", coil[7:4], 4'b0001);
        chk("t5p_pos", pos[7:4], 4'd1);
        tick(1);
        chk("t5p_hold", coil[7:4], 4'b0001);

        // Reset in the middle of a move.
        send(3'd0, 1'b0, 2'd0, 100, 2, 1'b1);
        tick(5);
        chk("t6_busy_pre", busy[0], 1'b1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("t6_coil", coil, 8'h00);
        chk("t6_busy", busy, 2'b00);
        chk("t6_done", done, 2'b00);
        chk("t6_err", cmd_err, 1'b0);
        chk("t6_pos", pos, 8'h00);
        tick(1);

        // 17 forward half steps from zero: position wraps to 1.
        expect_done(0, 4'd1, 4'b0011);
        send(3'd0, 1'b1, 2'd2, 17, 1, 1'b0);
        chk("t6w_k", coil[3:0], 4'b0001);
        tick(16);
        chk("t6w_busy16", busy[0], 1'b1);
        chk("t6w_pos16", pos[3:0], 4'd0);
        tick(1);
        chk("t6w_coil17", coil[3:0], 4'b0011);
        chk("t6w_busy17", busy[0], 1'b0);
        chk("t6w_pos17", pos[3:0], 4'd1);
        tick(1);
        chk("t6w_idle", coil[3:0], 4'b0000);
        tick(2);

        chk("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
